// File: rtl/seq_divmod_if.sv
// Handshake bundle between the prime generator (master) and the sequential
// divider/modulo unit (slave): go/a/b requests, ready/error/quot/mod results.
interface seq_divmod_if #(
    parameter int WIDTH = 16
);
    logic             go;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             error;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] mod;

    modport master (
        output go,
        output a,
        output b,
        input  ready,
        input  error,
        input  quot,
        input  mod
    );

    modport slave (
        input  go,
        input  a,
        input  b,
        output ready,
        output error,
        output quot,
        output mod
    );
endinterface

// File: rtl/seq_divmod.sv
// Sequential unsigned divider/modulo: restoring division, one quotient bit per
// cycle, started by a rising edge of go; divide-by-zero is flagged via error.
module seq_divmod #(
    parameter int WIDTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    seq_divmod_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ZDIV = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              go_prev_q, go_prev_d;
    logic [WIDTH-1:0]  dvd_q, dvd_d;
    logic [WIDTH-1:0]  dvs_q, dvs_d;
    logic [WIDTH-1:0]  rem_q, rem_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ready_q, ready_d;
    logic              error_q, error_d;
    logic [WIDTH-1:0]  quot_q, quot_d;
    logic [WIDTH-1:0]  mod_q, mod_d;

    logic              start_s;
    logic              last_s;
    logic              ge_s;
    logic [WIDTH:0]    rshift_s;
    logic [WIDTH-1:0]  diff_s;
    logic [WIDTH-1:0]  rem_next_s;
    logic [WIDTH-1:0]  dvd_next_s;

    // One restoring-division step and start-edge detection.
    always_comb begin
        start_s    = bus.go && !go_prev_q;
        last_s     = (cnt_q == CNT_W'(1));
        rshift_s   = {rem_q, dvd_q[WIDTH-1]};
        ge_s       = (rshift_s >= {1'b0, dvs_q});
        // When ge_s holds the true difference is below the divisor, so the
        // low WIDTH bits of the subtraction are exact.
        diff_s     = rshift_s[WIDTH-1:0] - dvs_q;
        rem_next_s = ge_s ? diff_s : rshift_s[WIDTH-1:0];
        // The dividend register doubles as the quotient shift register.
        dvd_next_s = {dvd_q[WIDTH-2:0], ge_s};
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            go_prev_q <= 1'b0;
            dvd_q     <= {WIDTH{1'b0}};
            dvs_q     <= {WIDTH{1'b0}};
            rem_q     <= {WIDTH{1'b0}};
            cnt_q     <= {CNT_W{1'b0}};
            ready_q   <= 1'b1;
            error_q   <= 1'b0;
            quot_q    <= {WIDTH{1'b0}};
            mod_q     <= {WIDTH{1'b0}};
        end else begin
            state_q   <= state_d;
            go_prev_q <= go_prev_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            ready_q   <= ready_d;
            error_q   <= error_d;
            quot_q    <= quot_d;
            mod_q     <= mod_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_s) begin
                    if (bus.b == {WIDTH{1'b0}}) begin
                        state_d = ZDIV;
                    end else begin
                        state_d = BUSY;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (last_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = BUSY;
                end
            end
            ZDIV:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next values.
    always_comb begin
        go_prev_d = bus.go;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        ready_d   = ready_q;
        error_d   = error_q;
        quot_d    = quot_q;
        mod_d     = mod_q;
        case (state_q)
            IDLE: begin
                if (start_s) begin
                    dvd_d   = bus.a;
                    dvs_d   = bus.b;
                    rem_d   = {WIDTH{1'b0}};
                    cnt_d   = CNT_W'(WIDTH);
                    ready_d = 1'b0;
                    error_d = 1'b0;
                end else begin
                    ready_d = ready_q;
                end
            end
            BUSY: begin
                dvd_d = dvd_next_s;
                rem_d = rem_next_s;
                cnt_d = cnt_q - CNT_W'(1);
                if (last_s) begin
                    quot_d  = dvd_next_s;
                    mod_d   = rem_next_s;
                    ready_d = 1'b1;
                end else begin
                    ready_d = 1'b0;
                end
            end
            ZDIV: begin
                quot_d  = {WIDTH{1'b1}};
                mod_d   = dvd_q;
                ready_d = 1'b1;
                error_d = 1'b1;
            end
            default: begin
                ready_d = 1'b1;
                error_d = 1'b0;
            end
        endcase
    end

    assign bus.ready = ready_q;
    assign bus.error = error_q;
    assign bus.quot  = quot_q;
    assign bus.mod   = mod_q;

endmodule

// File: tb/tb_seq_divmod.sv
// Directed-vector bench for seq_divmod: stimulus pushes expected results into a
// queue, a negedge monitor pops and compares on every rising edge of ready.
module tb_seq_divmod;
    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] m;
        logic         e;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    bit   mon_en;
    exp_t exp_q[$];

    seq_divmod_if #(.WIDTH(W)) bus ();

    seq_divmod #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: each 0->1 transition of ready is one completion.
    initial begin : monitor
        logic ready_prev;
        exp_t e;
        ready_prev = 1'b1;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (bus.ready === 1'b1 && ready_prev !== 1'b1) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_completion", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("quot", {16'd0, bus.quot}, {16'd0, e.q});
                        check("mod", {16'd0, bus.mod}, {16'd0, e.m});
                        check("error", {31'd0, bus.error}, {31'd0, e.e});
                    end
                end
                ready_prev = bus.ready;
            end
        end
    end

    // Pulse go for one cycle (edge E), push expectation, scramble operands after E.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] eq, input logic [W-1:0] em, input logic ee);
        exp_t e;
        bus.go = 1'b1;
        bus.a  = a;
        bus.b  = b;
        e.q = eq;
        e.m = em;
        e.e = ee;
        exp_q.push_back(e);
        @(negedge clk);
        bus.go = 1'b0;
        bus.a  = ~a;
        bus.b  = b ^ 16'h00A5;
        check("ready_low_after_E", {31'd0, bus.ready}, 32'd0);
    endtask

    // Count cycles until ready; optionally re-pulse go with other operands mid-op.
    task automatic wait_done(input int exp_lat, input int poke_at);
        int lat;
        lat = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (cyc == poke_at) begin
                bus.go = 1'b1;
                bus.a  = 16'd7;
                bus.b  = 16'd1;
            end else if (cyc == poke_at + 1) begin
                bus.go = 1'b0;
            end else begin
                bus.go = bus.go;
            end
            if (bus.ready === 1'b1 && lat == 0) lat = cyc;
            if (lat != 0 && cyc > poke_at + 1) break;
        end
        check("latency", lat, exp_lat);
    endtask

    initial begin : stim
        checks = 0;
        errors = 0;
        mon_en = 1'b0;
        rst    = 1'b1;
        bus.go = 1'b0;
        bus.a  = 16'd0;
        bus.b  = 16'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_ready", {31'd0, bus.ready}, 32'd1);
        check("rst_error", {31'd0, bus.error}, 32'd0);
        check("rst_quot", {16'd0, bus.quot}, 32'd0);
        check("rst_mod", {16'd0, bus.mod}, 32'd0);
        mon_en = 1'b1;
        @(negedge clk);

        start_op(16'd100, 16'd7, 16'd14, 16'd2, 1'b0);
        wait_done(W, -5);

        // Reset at E+5 aborts; monitor sees ready rise with reset values.
        start_op(16'd300, 16'd7, 16'd0, 16'd0, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_ready", {31'd0, bus.ready}, 32'd1);
        check("midrst_error", {31'd0, bus.error}, 32'd0);
        check("midrst_quot", {16'd0, bus.quot}, 32'd0);
        check("midrst_mod", {16'd0, bus.mod}, 32'd0);
        @(negedge clk);

        start_op(16'd1000, 16'd33, 16'd30, 16'd10, 1'b0);
        wait_done(W, -5);
        start_op(16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0);
        wait_done(W, -5);
        start_op(16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 1'b0);
        wait_done(W, -5);
        start_op(16'd3, 16'd10, 16'd0, 16'd3, 1'b0);
        wait_done(W, -5);
        start_op(16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1);
        wait_done(1, -5);
        start_op(16'd9, 16'd3, 16'd3, 16'd0, 1'b0);
        check("error_cleared_on_accept", {31'd0, bus.error}, 32'd0);
        wait_done(W, -5);

        // Re-pulse go mid-BUSY: must be ignored and not queued.
        start_op(16'd200, 16'd9, 16'd22, 16'd2, 1'b0);
        wait_done(W, 4);
        repeat (3) @(negedge clk);
        check("no_queued_op", {31'd0, bus.ready}, 32'd1);

        // go held high for 40 cycles: exactly one operation.
        begin
            exp_t e;
            bus.go = 1'b1;
            bus.a  = 16'd50;
            bus.b  = 16'd6;
            e.q = 16'd8;
            e.m = 16'd2;
            e.e = 1'b0;
            exp_q.push_back(e);
            for (int i = 1; i <= 40; i++) begin
                @(negedge clk);
                if (i == 1) check("hold_busy", {31'd0, bus.ready}, 32'd0);
                if (i >= W + 1) check("hold_ready_stays", {31'd0, bus.ready}, 32'd1);
            end
            bus.go = 1'b0;
            repeat (3) @(negedge clk);
            check("hold_after_release", {31'd0, bus.ready}, 32'd1);
        end

        repeat (2) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
